button_conditioner: RTL and testbench

- Upstream front end for the push-button sequencer FSM.
- Takes a raw, asynchronous, bouncy button input and synchronises it into the Clk domain.
- Debounces it with a saturating stability counter.
- Emits a clean one-cycle press pulse that drives the sequencer's B input, plus a debounced level for status display.

---
 rtl/button_pkg.sv | 15 +
 rtl/sync_2ff.sv | 25 ++
 rtl/button_conditioner.sv | 132 +++++++++++++
 tb/tb_button_conditioner.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared constants for the button conditioner: FSM state encodings and default
// debounce/repeat lengths, also imported by the testbench.
package button_pkg;

    localparam logic [1:0] S_Idle      = 2'd0;
    localparam logic [1:0] S_PressWait = 2'd1;
    localparam logic [1:0] S_Held      = 2'd2;
    localparam logic [1:0] S_RelWait   = 2'd3;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int CNT_W_DEF           = 16;
    localparam int REPEAT_CYCLES_DEF   = 8;
    localparam int RPT_W               = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit, cleared by an
// asynchronous active-low reset.
module sync_2ff (
    input  logic Clk,
    input  logic Rst_n,
    input  logic d_i,
    output logic q_o
);

    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
        end
    end

    assign q_o = sync2_q;

endmodule

// File: rtl/button_conditioner.sv
// Synchronises and debounces a raw push-button, producing a one-cycle press pulse
// and a debounced level. Define BUTTON_CONDITIONER_AUTOREPEAT_EN for held auto-repeat.
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF,
    parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic Btn,
    output logic Pulse,
    output logic Level
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 || (2 ** CNT_W) <= DEBOUNCE_CYCLES) begin : g_bad_debounce
        $error("button_conditioner: illegal DEBOUNCE_CYCLES/CNT_W");
    end
    if (REPEAT_CYCLES < 2 || REPEAT_CYCLES > 65535) begin : g_bad_repeat
        $error("button_conditioner: illegal REPEAT_CYCLES");
    end

    logic             btn_sync;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             level_q, level_d;

    sync_2ff u_sync (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .d_i   (Btn),
        .q_o   (btn_sync)
    );

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        level_d = level_q;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
        rpt_cnt_d = rpt_cnt_q;
`endif
        case (state_q)
            S_Idle: begin
                if (btn_sync) begin
                    state_d = S_PressWait;
                    cnt_d   = '0;
                end
            end
            S_PressWait: begin
                if (!btn_sync) begin
                    state_d = S_Idle;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_Held;
                    pulse_d = 1'b1;
                    level_d = 1'b1;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
                    rpt_cnt_d = '0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_Held: begin
                if (!btn_sync) begin
                    state_d = S_RelWait;
                    cnt_d   = '0;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
                    rpt_cnt_d = '0;
                end else if (rpt_cnt_q == RPT_LAST) begin
                    pulse_d   = 1'b1;
                    rpt_cnt_d = '0;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + 1'b1;
`endif
                end
            end
            S_RelWait: begin
                // A release bounce returns to Held silently; it is not a new press.
                if (btn_sync) begin
                    state_d = S_Held;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
                    rpt_cnt_d = '0;
`endif
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_Idle;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_Idle;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_Idle;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
        end
    end

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rpt_cnt_q <= '0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
        end
    end
`endif

    assign Pulse = pulse_q;
    assign Level = level_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised and directed bench for button_conditioner against a run-length
// behavioural model; honours BUTTON_CONDITIONER_AUTOREPEAT_EN.
module tb_button_conditioner;
    import button_pkg::*;

    localparam int D = DEBOUNCE_CYCLES_DEF;
    localparam int R = REPEAT_CYCLES_DEF;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    localparam bit AUTO    = 1'b1;
    localparam int EXP_RPT = 5;
`else
    localparam bit AUTO    = 1'b0;
    localparam int EXP_RPT = 1;
`endif

    logic Clk;
    logic Rst_n;
    logic Btn;
    logic Pulse;
    logic Level;

    int vectors;
    int miscompares;

    button_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (CNT_W_DEF),
        .REPEAT_CYCLES   (R)
    ) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .Btn   (Btn),
        .Pulse (Pulse),
        .Level (Level)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Model: the level flips after D+1 consecutive synchronised samples that
    // disagree with it; a steady held level emits a pulse every R samples.
    logic m_s1, m_s2, m_lvl, m_pulse;
    int   m_run, m_streak;

    always @(posedge Clk or negedge Rst_n) begin : model
        logic s, n_lvl, n_pulse;
        int   n_run, n_streak;
        if (!Rst_n) begin
            m_s1 <= 1'b0; m_s2 <= 1'b0; m_lvl <= 1'b0; m_pulse <= 1'b0;
            m_run <= 0; m_streak <= 0;
        end else begin
            s = m_s2;
            n_lvl = m_lvl; n_run = m_run; n_streak = m_streak; n_pulse = 1'b0;
            if (s != m_lvl) begin
                n_streak = 0;
                n_run = m_run + 1;
                if (n_run == D + 1) begin
                    n_lvl = s;
                    n_run = 0;
                    n_pulse = s;
                end
            end else begin
                if (m_lvl && m_run == 0) begin
                    n_streak = m_streak + 1;
                    if (n_streak == R) begin
                        n_pulse = AUTO;
                        n_streak = 0;
                    end
                end
                n_run = 0;
            end
            m_s1 <= Btn; m_s2 <= m_s1;
            m_lvl <= n_lvl; m_run <= n_run; m_streak <= n_streak; m_pulse <= n_pulse;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        check("model_pulse", 32'(Pulse), 32'(m_pulse));
        check("model_level", 32'(Level), 32'(m_lvl));
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #2;
        end
    endtask

    int pulses;

    initial begin
        vectors = 0;
        miscompares = 0;
        Btn   = 1'b1;
        Rst_n = 1'b0;

        // Reset held with button pressed, then treated as a fresh press.
        tick(3);
        check("reset_pulse", 32'(Pulse), 32'd0);
        check("reset_level", 32'(Level), 32'd0);
        Rst_n = 1'b1;
        tick(D + 2);
        check("rst_rel_pre_pulse", 32'(Pulse), 32'd0);
        tick(1);
        check("rst_rel_pulse", 32'(Pulse), 32'd1);
        tick(1);
        check("rst_rel_pulse_once", 32'(Pulse), 32'd0);

        // Release then clean press.
        Btn = 1'b0;
        tick(D + 2);
        check("release_level_pre", 32'(Level), 32'd1);
        tick(1);
        check("release_level", 32'(Level), 32'd0);
        check("release_no_pulse", 32'(Pulse), 32'd0);
        tick(10);
        Btn = 1'b1;
        tick(D + 2);
        check("press_pre_pulse", 32'(Pulse), 32'd0);
        check("press_pre_level", 32'(Level), 32'd0);
        tick(1);
        check("press_pulse", 32'(Pulse), 32'd1);
        check("press_level", 32'(Level), 32'd1);
        tick(1);
        check("press_pulse_once", 32'(Pulse), 32'd0);

        // Release bounce while held.
        Btn = 1'b0;
        tick(2);
        Btn = 1'b1;
        tick(10);
        check("relbounce_level", 32'(Level), 32'd1);

        // Async reset while held: level drops without a clock edge.
        @(negedge Clk);
        #1;
        Rst_n = 1'b0;
        #1;
        check("async_rst_level", 32'(Level), 32'd0);
        tick(2);
        Btn = 1'b0;
        Rst_n = 1'b1;
        tick(10);

        // Press bounce 1,0,1,0 then hold.
        for (int k = 0; k < 2; k++) begin
            Btn = 1'b1; tick(2);
            Btn = 1'b0; tick(2);
        end
        Btn = 1'b1;
        tick(D + 2);
        check("bounce_pre_pulse", 32'(Pulse), 32'd0);
        tick(1);
        check("bounce_pulse", 32'(Pulse), 32'd1);
        Btn = 1'b0;
        tick(15);

        // Async reset mid-debounce, between edges 4 and 5 of a press.
        Btn = 1'b1;
        tick(4);
        Rst_n = 1'b0;
        #1;
        check("middeb_pulse", 32'(Pulse), 32'd0);
        check("middeb_level", 32'(Level), 32'd0);
        tick(2);
        Rst_n = 1'b1;
        tick(D + 3);
        check("middeb_after_pulse", 32'(Pulse), 32'd1);
        Btn = 1'b0;
        tick(15);

        // Held 40 cycles: auto-repeat count.
        pulses = 0;
        Btn = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick(1);
            if (Pulse) pulses++;
        end
        check("repeat_count", 32'(pulses), 32'(EXP_RPT));
        Btn = 1'b0;
        tick(15);

        // Random bouncy traffic with occasional async resets.
        for (int seg = 0; seg < 200; seg++) begin
            Btn = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) begin
                #1;
                Rst_n = 1'b0;
                tick(1);
                Rst_n = 1'b1;
            end
            tick($urandom_range(1, 14));
        end

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
